// File: rtl/iot_pkg.sv
// Shared definitions for the IoT filter transmit front end.
// Contents: word/byte geometry, function-select codes understood by the filter core,
// and the serializer state type.
package iot_pkg;

  localparam int unsigned WORD_W         = 128;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;

  // Function codes driven on fn_sel.
  localparam logic [2:0] FN_MAX  = 3'd1;
  localparam logic [2:0] FN_MIN  = 3'd2;
  localparam logic [2:0] FN_AVG  = 3'd3;
  localparam logic [2:0] FN_EXT  = 3'd4;
  localparam logic [2:0] FN_EXC  = 3'd5;
  localparam logic [2:0] FN_PMAX = 3'd6;
  localparam logic [2:0] FN_PMIN = 3'd7;

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_e;

endpackage

// File: rtl/iot_tx_if.sv
// Bundle of the upstream word handshake and the downstream filter-core byte stream.
//   fn_cfg     : requested function code (sampled by the serializer at round start)
//   s_valid/s_data/s_ready : upstream 128-bit word handshake
//   busy       : back-pressure from the filter core
//   in_en/iot_in/fn_sel    : byte stream to the core
//   round_done : pulse with the last byte of a round
//   word_idx   : index of the word being sent within the round
// Modport master: the side that feeds words and models the core.
// Modport slave : the transmit block itself.
interface iot_tx_if;
  import iot_pkg::*;

  logic [2:0]        fn_cfg;
  logic              s_valid;
  logic [WORD_W-1:0] s_data;
  logic              s_ready;
  logic              busy;
  logic              in_en;
  logic [BYTE_W-1:0] iot_in;
  logic [2:0]        fn_sel;
  logic              round_done;
  logic [2:0]        word_idx;

  modport master (
    output fn_cfg, s_valid, s_data, busy,
    input  s_ready, in_en, iot_in, fn_sel, round_done, word_idx
  );

  modport slave (
    input  fn_cfg, s_valid, s_data, busy,
    output s_ready, in_en, iot_in, fn_sel, round_done, word_idx
  );

endinterface

// File: rtl/iot_tx_fifo.sv
// DEPTH x 128-bit word FIFO with synchronous write and a combinational head.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   i_push     : write i_din this cycle (never asserted while full)
//   i_din      : word to write
//   i_pop      : drop the head word this cycle (never asserted while empty)
//   o_head     : word at the read pointer
//   o_count    : number of stored words (0..DEPTH)
//   o_full     : count == DEPTH
//   o_empty    : count == 0
module iot_tx_fifo
  import iot_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WORD_W-1:0]          i_din,
  input  logic                       i_pop,
  output logic [WORD_W-1:0]          o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CntW-1:0]   r_count;

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap without compare logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      r_count <= r_count + CntW'(i_push) - CntW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CntW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/iot_tx.sv
// Transmit front end: buffers 128-bit words and serializes them MSB byte first onto the
// filter-core byte stream, grouping words into rounds with a constant function select.
//   clk, rst_n : clock, asynchronous active-low reset
//   if_bus     : iot_tx_if slave modport (word handshake in, byte stream out)
// All byte-stream outputs are registered; s_ready depends only on the FIFO count.
module iot_tx
  import iot_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned WORDS_PER_ROUND = 8
) (
  input logic   clk,
  input logic   rst_n,
  iot_tx_if.slave if_bus
);

  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam int unsigned ByteW = $clog2(BYTES_PER_WORD);

  logic [WORD_W-1:0] w_head;
  logic [CntW-1:0]   w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  tx_state_e         r_state,      w_state_nxt;
  logic [WORD_W-1:0] r_shift,      w_shift_nxt;
  logic [ByteW-1:0]  r_byte,       w_byte_nxt;   // index of the next byte to issue
  logic              r_in_en,      w_in_en_nxt;
  logic [BYTE_W-1:0] r_iot_in,     w_iot_in_nxt;
  logic [2:0]        r_fn_sel,     w_fn_sel_nxt;
  logic              r_round_done, w_round_done_nxt;
  logic [2:0]        r_word_idx,   w_word_idx_nxt;
  logic              r_last,       w_last_nxt;   // byte on the output is byte 15
  logic [2:0]        w_idx_inc;
  logic [2:0]        w_cur_idx;

  assign w_push         = if_bus.s_valid && !w_full;
  assign if_bus.s_ready = (w_count < CntW'(DEPTH));

  iot_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (if_bus.s_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_idx_inc = (r_word_idx == 3'(WORDS_PER_ROUND - 1)) ? 3'd0 : r_word_idx + 3'd1;

  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_byte_nxt       = r_byte;
    w_in_en_nxt      = 1'b0;
    w_iot_in_nxt     = r_iot_in;
    w_fn_sel_nxt     = r_fn_sel;
    w_round_done_nxt = 1'b0;
    w_word_idx_nxt   = r_word_idx;
    w_last_nxt       = 1'b0;
    w_pop            = 1'b0;
    w_cur_idx        = r_word_idx;

    // word_idx advances once byte 15 has been on the output; a byte 0 issued on this
    // same edge already belongs to the following word.
    if (r_last) begin
      w_word_idx_nxt = w_idx_inc;
      w_cur_idx      = w_idx_inc;
    end

    unique case (r_state)
      IDLE: begin
        if (!w_empty && !if_bus.busy) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_byte_nxt  = '0;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        // busy holds shift register and byte index; in_en drops via its default.
        if (!if_bus.busy) begin
          w_in_en_nxt  = 1'b1;
          w_iot_in_nxt = r_shift[WORD_W-1 -: BYTE_W];
          w_shift_nxt  = {r_shift[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
          w_byte_nxt   = r_byte + ByteW'(1);
          if (r_byte == '0 && w_cur_idx == 3'd0) begin
            w_fn_sel_nxt = if_bus.fn_cfg;
          end
          if (r_byte == ByteW'(BYTES_PER_WORD - 1)) begin
            w_last_nxt       = 1'b1;
            w_round_done_nxt = (w_cur_idx == 3'(WORDS_PER_ROUND - 1));
            if (!w_empty) begin
              // Back-to-back load so the next byte 0 follows without a bubble.
              w_pop       = 1'b1;
              w_shift_nxt = w_head;
              w_byte_nxt  = '0;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_byte       <= '0;
      r_in_en      <= 1'b0;
      r_iot_in     <= '0;
      r_fn_sel     <= '0;
      r_round_done <= 1'b0;
      r_word_idx   <= '0;
      r_last       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_byte       <= w_byte_nxt;
      r_in_en      <= w_in_en_nxt;
      r_iot_in     <= w_iot_in_nxt;
      r_fn_sel     <= w_fn_sel_nxt;
      r_round_done <= w_round_done_nxt;
      r_word_idx   <= w_word_idx_nxt;
      r_last       <= w_last_nxt;
    end
  end

  assign if_bus.in_en      = r_in_en;
  assign if_bus.iot_in     = r_iot_in;
  assign if_bus.fn_sel     = r_fn_sel;
  assign if_bus.round_done = r_round_done;
  assign if_bus.word_idx   = r_word_idx;

endmodule

// File: tb/tb_iot_tx.sv
// Self-checking bench for iot_tx: every accepted word queues its 16 expected bytes
// (byte, fn_sel, word_idx, round_done); a negedge monitor pops and compares them.
module tb_iot_tx;
  import iot_pkg::*;

  logic clk;
  logic rst_n;

  iot_tx_if bus ();

  iot_tx #(
    .DEPTH           (4),
    .WORDS_PER_ROUND (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .if_bus (bus)
  );

  typedef struct packed {
    logic [7:0] b;
    logic [2:0] fs;
    logic [2:0] wi;
    logic       rd;
  } exp_t;

  typedef struct {
    logic [2:0]   fn_cfg;
    logic [127:0] data;
    logic [2:0]   exp_fn;
    logic [2:0]   exp_wi;
  } vec_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   first_cyc = -1;
  int   last_cyc = 0;
  int   rd_cyc = 0;
  int   n_bytes = 0;
  int   n_rd = 0;
  int   acc_cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [127:0] mk_word(input int w);
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[127-8*k -: 8] = {w[3:0], k[3:0]};
    return d;
  endfunction

  task automatic sb_add(input logic [127:0] d, input logic [2:0] wi, input logic [2:0] fs);
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      e.b  = d[127-8*k -: 8];
      e.fs = fs;
      e.wi = wi;
      e.rd = (k == 15) && (wi == 3'd7);
      sb.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push_word(input logic [127:0] d, input logic [2:0] wi, input logic [2:0] fs);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    while (!bus.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) begin
      chk(1'b0, "push_timeout", 32'(bus.s_ready), 32'd1);
    end else begin
      sb_add(d, wi, fs);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_byte(input logic [7:0] b, input logic [2:0] wi, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < 2000) begin
      @(negedge clk);
      n++;
      ok = bus.in_en && bus.iot_in == b && bus.word_idx == wi;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk(sb.size() == 0, name, 32'(sb.size()), 32'd0);
  endtask

  task automatic clr_stats();
    first_cyc = -1;
    last_cyc  = 0;
    rd_cyc    = 0;
    n_bytes   = 0;
    n_rd      = 0;
  endtask

  task automatic do_reset();
    bus.s_valid = 1'b0;
    bus.busy    = 1'b0;
    rst_n       = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr_stats();
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (rst_n && bus.in_en) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        n_bytes++;
        if (bus.round_done) begin
          n_rd++;
          rd_cyc = cyc;
        end
        a.b  = bus.iot_in;
        a.fs = bus.fn_sel;
        a.wi = bus.word_idx;
        a.rd = bus.round_done;
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_byte{b,fn,wi,rd}", 32'(a), 32'h0);
        end else begin
          e = sb.pop_front();
          chk(a == e, "stream_byte{b,fn,wi,rd}", 32'(a), 32'(e));
        end
      end else if (rst_n && bus.round_done) begin
        n_rd++;
        chk(1'b0, "round_done_without_in_en", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    vec_t tbl[9];
    bit   ok;

    for (int i = 0; i < 9; i++) begin
      tbl[i].fn_cfg = (i < 3) ? 3'd6 : 3'd1;
      tbl[i].data   = mk_word(i);
      tbl[i].exp_fn = (i < 8) ? 3'd6 : 3'd1;
      tbl[i].exp_wi = 3'(i % 8);
    end

    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.busy    = 1'b0;
    bus.fn_cfg  = 3'd0;
    repeat (3) @(negedge clk);
    chk(bus.s_ready == 1'b1, "por_s_ready", 32'(bus.s_ready), 32'd1);
    chk(bus.in_en == 1'b0, "por_in_en", 32'(bus.in_en), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during byte 7 of word 3, then a fresh round.
    bus.fn_cfg = 3'd2;
    for (int w = 0; w < 5; w++) push_word(mk_word(w), 3'(w), 3'd2);
    wait_byte(8'h37, 3'd3, ok);
    chk(ok, "reach_word3_byte7", 32'(ok), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk(bus.in_en == 1'b0, "rst_in_en", 32'(bus.in_en), 32'd0);
    chk(bus.iot_in == 8'h00, "rst_iot_in", 32'(bus.iot_in), 32'd0);
    chk(bus.fn_sel == 3'd0, "rst_fn_sel", 32'(bus.fn_sel), 32'd0);
    chk(bus.round_done == 1'b0, "rst_round_done", 32'(bus.round_done), 32'd0);
    chk(bus.word_idx == 3'd0, "rst_word_idx", 32'(bus.word_idx), 32'd0);
    chk(bus.s_ready == 1'b1, "rst_s_ready", 32'(bus.s_ready), 32'd1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr_stats();
    bus.fn_cfg = 3'd4;
    push_word(128'h00112233445566778899AABBCCDDEEFF, 3'd0, 3'd4);
    wait_drain("drain_after_reset");

    // Single word: latency and length.
    do_reset();
    bus.fn_cfg = 3'd3;
    push_word(mk_word(0), 3'd0, 3'd3);
    acc_cyc = cyc;
    wait_drain("drain_single");
    chk(first_cyc - acc_cyc == 2, "first_byte_latency", 32'(first_cyc - acc_cyc), 32'd2);
    chk(last_cyc - first_cyc == 15, "byte15_offset", 32'(last_cyc - first_cyc), 32'd15);
    chk(n_bytes == 16, "single_byte_count", 32'(n_bytes), 32'd16);

    // Back-to-back round plus the first word of the next round, from the table.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus.fn_cfg = tbl[i].fn_cfg;
      push_word(tbl[i].data, tbl[i].exp_wi, tbl[i].exp_fn);
    end
    wait_drain("drain_round");
    chk(last_cyc - first_cyc + 1 == 144, "continuous_run", 32'(last_cyc - first_cyc + 1),
        32'd144);
    chk(n_bytes == 144, "round_byte_count", 32'(n_bytes), 32'd144);
    chk(n_rd == 1, "round_done_pulses", 32'(n_rd), 32'd1);
    chk(rd_cyc - first_cyc + 1 == 128, "round_done_cycle", 32'(rd_cyc - first_cyc + 1),
        32'd128);

    // Back-pressure while byte 5 is pending.
    do_reset();
    bus.fn_cfg = 3'd3;
    push_word(mk_word(0), 3'd0, 3'd3);
    wait_byte(8'h04, 3'd0, ok);
    chk(ok, "reach_byte4", 32'(ok), 32'd1);
    bus.busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk(bus.in_en == 1'b0, "busy_gap", 32'(bus.in_en), 32'd0);
    end
    bus.busy = 1'b0;
    @(negedge clk);
    chk(bus.in_en && bus.iot_in == 8'h05, "resume_byte5", {23'd0, bus.in_en, bus.iot_in},
        32'h105);
    wait_drain("drain_busy");

    // FIFO full with busy held, extra word stalls until the first pop.
    do_reset();
    bus.fn_cfg = 3'd7;
    bus.busy   = 1'b1;
    for (int i = 0; i < 4; i++) push_word(mk_word(i), 3'(i), 3'd7);
    bus.s_valid = 1'b1;
    bus.s_data  = mk_word(4);
    chk(bus.s_ready == 1'b0, "full_after_depth", 32'(bus.s_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk(bus.s_ready == 1'b0, "stall_while_busy", 32'(bus.s_ready), 32'd0);
    chk(bus.in_en == 1'b0, "no_bytes_while_busy", 32'(bus.in_en), 32'd0);
    bus.busy = 1'b0;
    @(negedge clk);
    chk(bus.s_ready == 1'b1, "ready_after_first_pop", 32'(bus.s_ready), 32'd1);
    sb_add(mk_word(4), 3'd4, 3'd7);
    @(negedge clk);
    bus.s_valid = 1'b0;
    chk(bus.s_ready == 1'b0, "refilled_after_accept", 32'(bus.s_ready), 32'd0);
    wait_drain("drain_full");
    chk(n_bytes == 80, "full_byte_count", 32'(n_bytes), 32'd80);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/iot_tx.md
# iot_tx

Transmit-side front end for the IoT data-filter stream. Accepts 128-bit sensor words over a valid/ready handshake, buffers them in a small FIFO, and serializes each word MSB-byte-first onto the 8-bit `in_en`/`iot_in`/`fn_sel` byte stream consumed by the filter core. It groups words into rounds of 8 and holds the function select constant across each round. It honors the core's `busy` back-pressure.

## Interface
Parameters:
- `DEPTH`, 4: FIFO depth in 128-bit words (power of two, ≥2).
- `WORDS_PER_ROUND`, 8: words per round; `fn_sel` is constant within a round.

Ports:
- `clk`  in  1  single clock, all flops rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fn_cfg`  in  3  requested function code; sampled only at round start.
- `s_valid`  in  1  upstream word valid.
- `s_data`  in  128  upstream word.
- `s_ready`  out  1  FIFO can accept a word.
- `busy`  in  1  back-pressure from the filter core.
- `in_en`  out  1  byte strobe to the core.
- `iot_in`  out  8  byte to the core.
- `fn_sel`  out  3  function code to the core.
- `round_done`  out  1  one-cycle pulse with the last byte of a round.
- `word_idx`  out  3  index of the word currently being sent within the round (0..WORDS_PER_ROUND-1).

## Operation
- Push: a word is written when `s_valid && s_ready`. `s_ready = (count < DEPTH)`. A pop in the same cycle is ignored when computing `s_ready`. `s_data` is captured unmodified.
- Serializer states:
  - IDLE: waits for FIFO non-empty. With `busy=0`, pops the head word into the shift register and goes to SEND.
  - SEND: emits byte `k` (k=0..15), where byte 0 = bits [127:120] and byte 15 = bits [7:0].
- After byte 15:
  - If the FIFO is non-empty and `busy=0`, the next word is loaded and its byte 0 goes out on the following cycle with no bubble.
  - Otherwise the serializer returns to IDLE.
- Bubbles: `in_en=0` between words is legal; bubbles never occur inside a word unless `busy` is asserted.
- Busy handling: if `busy=1` at a rising edge, the next cycle has `in_en=0` and the byte index, shift register and `word_idx` all hold. Sending resumes at the same byte on the cycle after `busy` is sampled low.
- Round tracking: `word_idx` increments after byte 15 of each word and wraps from WORDS_PER_ROUND-1 to 0.
  - `fn_sel` loads from `fn_cfg` when byte 0 of a word with `word_idx==0` is issued, and is held for the whole round.
  - Changes on `fn_cfg` mid-round have no effect.
  - `round_done=1` in the same cycle as byte 15 of word WORDS_PER_ROUND-1.
- Pointer and count arithmetic: FIFO pointers are log2(DEPTH) bits and wrap naturally. `count` is log2(DEPTH)+1 bits. Push to a full FIFO and pop from an empty FIFO are both impossible by construction.

## Timing
- Reset (`rst_n=0`, asynchronous):
  - `in_en=0`, `iot_in=0`, `fn_sel=0`, `round_done=0`, `word_idx=0`.
  - FIFO is emptied, so `s_ready=1`.
  - Serializer goes to IDLE.
- Reset asserted mid-word or mid-round: everything is discarded. After release, the first transmitted word starts a new round with `word_idx=0`, and `fn_sel` is resampled.
- Outputs `in_en`, `iot_in`, `fn_sel`, `round_done` and `word_idx` are registered.
- Latency: word accepted at edge N into an empty FIFO with the serializer idle gives byte 0 valid after edge N+2.
  - One cycle for the FIFO write and one for load/issue.
  - Byte 15 appears 15 cycles after byte 0 when `busy=0`.
- Throughput: one byte per cycle sustained, i.e. 16 cycles per word, provided the FIFO never runs empty.
- `s_ready` is combinational from registered `count` only; it never depends on `s_valid`.

## Structure
- Package `iot_pkg`:
  - function-code constants FN_MAX=1, FN_MIN=2, FN_AVG=3, FN_EXT=4, FN_EXC=5, FN_PMAX=6, FN_PMIN=7;
  - `BYTES_PER_WORD=16`;
  - serializer state enum {IDLE, SEND}.
- Sub-module `iot_tx_fifo`: a DEPTH×128 synchronous-write FIFO with `push`, `pop`, `head`, `count`, `full` and `empty`.
- Top level `iot_tx` holds the serializer FSM, byte counter, round counter and `fn_sel` register.

## Test plan
- Reset mid-round: reset asserted during byte 7 of word 3 → all outputs 0 immediately. After release, push `128'h00112233445566778899AABBCCDDEEFF` → first byte 8'h00, `word_idx=0`, `fn_sel` resampled.
- Single word: `fn_cfg=3`, push `128'h000102…0F` → `in_en` high 16 cycles starting 2 cycles after acceptance, `iot_in` = 8'h00..8'h0F in order, `fn_sel=3` throughout.
- Back-to-back round: push 8 words with the FIFO kept fed, `fn_cfg=6` at start, switched to 1 after word 2 →
  - 128 consecutive `in_en` cycles, with `fn_sel=6` for all of them;
  - `round_done` on cycle 128 only;
  - the next round uses `fn_sel=1`.
- Back-pressure: `busy=1` for 3 cycles while byte 5 (8'h05) is pending → `in_en=0` for 3 cycles, then 8'h05 resumes with no byte lost or duplicated.
- FIFO full: DEPTH+1 words offered with `busy=1` held → `s_ready` drops after DEPTH words are accepted, the extra word is stalled, and it is accepted as soon as the first pop occurs after `busy` falls.
